// File: rtl/mux_8x1_4x1.sv
// mux_8x1_4x1: 8:1 mux built from two 4:1 stages and a final 2:1 stage,
// with a combinational output y and a registered copy y_q.
module mux_2x1 #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0] y_o,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic             sel_i
);
  assign y_o = sel_i ? in1_i : in0_i;
endmodule

module mux_4x1 #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0]   y_o,
  input  logic [4*WIDTH-1:0] d_i,
  input  logic [1:0]         s_i
);
  logic [WIDTH-1:0] a, b;
  mux_2x1 #(.WIDTH(WIDTH)) u_a (.y_o(a), .in0_i(d_i[0*WIDTH +: WIDTH]), .in1_i(d_i[1*WIDTH +: WIDTH]), .sel_i(s_i[0]));
  mux_2x1 #(.WIDTH(WIDTH)) u_b (.y_o(b), .in0_i(d_i[2*WIDTH +: WIDTH]), .in1_i(d_i[3*WIDTH +: WIDTH]), .sel_i(s_i[0]));
  mux_2x1 #(.WIDTH(WIDTH)) u_c (.y_o(y_o), .in0_i(a), .in1_i(b), .sel_i(s_i[1]));
endmodule

module mux_8x1_4x1 #(
  parameter int WIDTH = 1
) (
  output logic [WIDTH-1:0]   y,
  input  logic [8*WIDTH-1:0] i,
  input  logic [2:0]         s,
  input  logic               clk,
  input  logic               rst_n,
  output logic [WIDTH-1:0]   y_q
);
  logic [WIDTH-1:0] lo, hi;
  mux_4x1 #(.WIDTH(WIDTH)) u_lo (.y_o(lo), .d_i(i[4*WIDTH-1:0]), .s_i(s[1:0]));
  mux_4x1 #(.WIDTH(WIDTH)) u_hi (.y_o(hi), .d_i(i[8*WIDTH-1:4*WIDTH]), .s_i(s[1:0]));
  mux_2x1 #(.WIDTH(WIDTH)) u_out (.y_o(y), .in0_i(lo), .in1_i(hi), .sel_i(s[2]));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= '0;
    else        y_q <= y;
  end
endmodule

// File: tb/tb_mux_8x1_4x1.sv
// tb_mux_8x1_4x1: directed sweeps, free-running select and async reset,
// with expected values queued by the stimulus and checked by a monitor.
module tb_mux_8x1_4x1;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       y, y_q;
  logic [7:0] i;
  logic [2:0] s;

  always #5 clk = ~clk;

  mux_8x1_4x1 #(.WIDTH(1)) dut (.y(y), .i(i), .s(s), .clk(clk), .rst_n(rst_n), .y_q(y_q));

  typedef struct {
    logic  ey;
    logic  eq;
    string tag;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  logic prev_y = 1'b0;
  logic prev_rst = 1'b0;
  logic mq = 1'b0;

  // Hand-computed y for s = 0..7 (leftmost bit is s=0) for 00, 10, 1A, 0F.
  logic [7:0] pats [4] = '{8'h00, 8'h10, 8'h1A, 8'h0F};
  logic [0:7] exps [4] = '{8'b0000_0000, 8'b0000_1000, 8'b0101_1000, 8'b1111_0000};

  // One call per clock: inputs change 2 ns after the edge, expectation is queued.
  task automatic step(input logic [7:0] ni, input logic [2:0] ns, input logic nr,
                      input logic ey, input string tag);
    @(posedge clk);
    mq = prev_rst ? prev_y : 1'b0;
    #2;
    i = ni;
    s = ns;
    rst_n = nr;
    if (!nr) mq = 1'b0;
    prev_y = ey;
    prev_rst = nr;
    q.push_back('{ey, mq, tag});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        compared++;
        if (y !== e.ey) begin
          mismatched++;
          $display("FAIL %s y: got %b expected %b", e.tag, y, e.ey);
        end
        compared++;
        if (y_q !== e.eq) begin
          mismatched++;
          $display("FAIL %s y_q: got %b expected %b", e.tag, y_q, e.eq);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] ni;
    logic [2:0] ns;
    #1 rst_n = 1'b0;
    step(8'hFF, 3'd0, 1'b0, 1'b1, "reset_hold");
    step(8'hFF, 3'd5, 1'b0, 1'b1, "reset_hold");
    step(8'h00, 3'd0, 1'b1, 1'b0, "reset_release");
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 8; k++) begin
        step(pats[p], 3'(k), 1'b1, exps[p][k], $sformatf("sweep_%h_s%0d_a", pats[p], k));
        step(pats[p], 3'(k), 1'b1, exps[p][k], $sformatf("sweep_%h_s%0d_b", pats[p], k));
      end
    // s advances every 10 cycles (100 ns): s[0] 100 ns, s[1] 200 ns, s[2] 400 ns.
    for (int c = 0; c < 320; c++) begin
      ni = pats[c / 80];
      ns = 3'((c / 10) % 8);
      step(ni, ns, 1'b1, ni[ns], $sformatf("free_c%0d", c));
    end
    step(8'hFF, 3'd6, 1'b1, 1'b1, "rst_pre");
    step(8'hFF, 3'd6, 1'b1, 1'b1, "rst_pre_q");
    step(8'hFF, 3'd6, 1'b0, 1'b1, "rst_async_drop");
    step(8'hFF, 3'd2, 1'b0, 1'b1, "rst_low_edge");
    step(8'hFF, 3'd2, 1'b1, 1'b1, "rst_release");
    step(8'hFF, 3'd2, 1'b1, 1'b1, "rst_first_capture");
    step(8'h1A, 3'd3, 1'b1, 1'b1, "post_rst");
    for (int w = 0; w < 20 && q.size() != 0; w++) @(posedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
